bus_stable_capture: RTL and testbench

- Downstream consumer of a per-bit multi-flop bus synchronizer, in the destination clock domain.
- Per-bit synchronization of a multi-bit bus can produce transient mixed old/new codes.
- This block qualifies the synchronized bus by requiring the same value for STBLCYC consecutive cycles before committing it. It then presents the committed value with a one-cycle update strobe and counts aborted qualifications for debug.

---
 rtl/bus_stable_capture.sv | 139 +++++++++++++
 tb/tb_bus_stable_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_stable_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_stable_capture
//  Description : Qualifies a per-bit synchronized bus. A value is committed to
//                data_out only after it has been seen on data_in for STBLCYC
//                consecutive cycles. Each commit produces a one-cycle data_vld
//                pulse. Aborted or restarted qualifications are counted in a
//                saturating, clearable glitch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_stable_capture #(
  parameter int                 DATAWTH = 8,
  parameter int                 STBLCYC = 3,
  parameter logic [DATAWTH-1:0] INITVAL = '0,
  parameter int                 CNTWTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATAWTH-1:0] data_in,
  input  logic               glitch_clr,
  output logic [DATAWTH-1:0] data_out,
  output logic               data_vld,
  output logic               busy,
  output logic [CNTWTH-1:0]  glitch_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_t;

  // Run-length target in the width of the run counter.
  localparam logic [7:0]        c_stbl_cyc = 8'(STBLCYC);
  localparam logic [CNTWTH-1:0] c_gc_max   = {CNTWTH{1'b1}};

  state_t               state_q, state_d;
  logic [DATAWTH-1:0]   cand_q, cand_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [DATAWTH-1:0]   data_out_q, data_out_d;
  logic                 data_vld_q, data_vld_d;
  logic                 busy_q, busy_d;
  logic [CNTWTH-1:0]    glitch_cnt_q, glitch_cnt_d;
  logic                 w_glitch_inc;

  // Qualification FSM: decides candidate tracking, commits and glitch events.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_vld_d   = 1'b0;
    w_glitch_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_in != data_out_q) begin
          if (STBLCYC == 1) begin
            // A single sample is already enough to commit.
            data_out_d = data_in;
            data_vld_d = 1'b1;
          end else begin
            cand_d  = data_in;
            cnt_d   = 8'd1;
            state_d = QUAL;
          end
        end
      end

      QUAL: begin
        if (data_in == cand_q) begin
          if (cnt_q + 8'd1 == c_stbl_cyc) begin
            data_out_d = cand_q;
            data_vld_d = 1'b1;
            cnt_d      = 8'd0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (data_in == data_out_q) begin
          // Bus fell back to the committed value: candidate was a glitch.
          cnt_d        = 8'd0;
          state_d      = IDLE;
          w_glitch_inc = 1'b1;
        end else begin
          // A different new value appeared: requalify from scratch.
          cand_d       = data_in;
          cnt_d        = 8'd1;
          w_glitch_inc = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    busy_d = (state_d == QUAL);
  end

  // Glitch counter: clear wins over increment, saturates at all-ones.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (w_glitch_inc && (glitch_cnt_q != c_gc_max)) begin
      glitch_cnt_d = glitch_cnt_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cand_q       <= INITVAL;
      cnt_q        <= 8'd0;
      data_out_q   <= INITVAL;
      data_vld_q   <= 1'b0;
      busy_q       <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_vld_q   <= data_vld_d;
      busy_q       <= busy_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_vld   = data_vld_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_stable_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bus_stable_capture
//  Description : Directed bench for bus_stable_capture. Three instances cover
//                STBLCYC=3, a 2-bit glitch counter, and STBLCYC=1. Expected
//                commits are queued when stimulus is driven and popped when
//                the DUT pulses data_vld.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_stable_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din_a, din_s, din_o;
  logic       clr_a, clr_s, clr_o;

  logic [7:0] dout_a, dout_s, dout_o;
  logic       vld_a, vld_s, vld_o;
  logic       busy_a, busy_s, busy_o;
  logic [7:0] gc_a, gc_o;
  logic [1:0] gc_s;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_a[$];
  logic [7:0] sb_s[$];
  logic [7:0] sb_o[$];

  bus_stable_capture #(.DATAWTH(8), .STBLCYC(3), .INITVAL(8'h00), .CNTWTH(8)) u_a (
    .clk(clk), .rst(rst), .data_in(din_a), .glitch_clr(clr_a),
    .data_out(dout_a), .data_vld(vld_a), .busy(busy_a), .glitch_cnt(gc_a)
  );

  bus_stable_capture #(.DATAWTH(8), .STBLCYC(3), .INITVAL(8'h00), .CNTWTH(2)) u_s (
    .clk(clk), .rst(rst), .data_in(din_s), .glitch_clr(clr_s),
    .data_out(dout_s), .data_vld(vld_s), .busy(busy_s), .glitch_cnt(gc_s)
  );

  bus_stable_capture #(.DATAWTH(8), .STBLCYC(1), .INITVAL(8'h00), .CNTWTH(8)) u_o (
    .clk(clk), .rst(rst), .data_in(din_o), .glitch_clr(clr_o),
    .data_out(dout_o), .data_vld(vld_o), .busy(busy_o), .glitch_cnt(gc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] e_out, input logic e_vld,
                       input logic e_busy, input logic [7:0] e_gc);
    chk({tag, ".data_out"}, 32'(dout_a), 32'(e_out));
    chk({tag, ".data_vld"}, 32'(vld_a), 32'(e_vld));
    chk({tag, ".busy"}, 32'(busy_a), 32'(e_busy));
    chk({tag, ".glitch_cnt"}, 32'(gc_a), 32'(e_gc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every data_vld pulse must match the oldest queued commit.
  always @(negedge clk) begin
    if (vld_a === 1'b1) begin
      if (sb_a.size() == 0) chk("a.unexpected_vld", 32'(vld_a), 32'd0);
      else                  chk("a.commit", 32'(dout_a), 32'(sb_a.pop_front()));
    end
    if (vld_s === 1'b1) begin
      if (sb_s.size() == 0) chk("s.unexpected_vld", 32'(vld_s), 32'd0);
      else                  chk("s.commit", 32'(dout_s), 32'(sb_s.pop_front()));
    end
    if (vld_o === 1'b1) begin
      if (sb_o.size() == 0) chk("o.unexpected_vld", 32'(vld_o), 32'd0);
      else                  chk("o.commit", 32'(dout_o), 32'(sb_o.pop_front()));
    end
  end

  initial begin
    rst   = 1'b1;
    din_a = 8'h5A;
    din_s = 8'h00;
    din_o = 8'h00;
    clr_a = 1'b0;
    clr_s = 1'b0;
    clr_o = 1'b0;

    // Reset values, during and one cycle after reset
    tick(); chk_a("rst0", 8'h00, 1'b0, 1'b0, 8'd0);
    tick(); chk_a("rst1", 8'h00, 1'b0, 1'b0, 8'd0);
    chk("rst.s.gc", 32'(gc_s), 32'd0);
    chk("rst.o.out", 32'(dout_o), 32'd0);
    rst = 1'b0; din_a = 8'h00;
    tick(); chk_a("post_rst", 8'h00, 1'b0, 1'b0, 8'd0);

    // Clean change 00 -> 3C
    din_a = 8'h3C; sb_a.push_back(8'h3C);
    tick(); chk_a("clean_e0", 8'h00, 1'b0, 1'b1, 8'd0);
    tick(); chk_a("clean_e1", 8'h00, 1'b0, 1'b1, 8'd0);
    tick(); chk_a("clean_e2", 8'h3C, 1'b1, 1'b0, 8'd0);
    tick(); chk_a("clean_e3", 8'h3C, 1'b0, 1'b0, 8'd0);

    // Return to 00 for the following tests
    din_a = 8'h00; sb_a.push_back(8'h00);
    tick(); tick();
    tick(); chk_a("back0", 8'h00, 1'b1, 1'b0, 8'd0);
    tick();

    // Single-cycle glitch
    din_a = 8'hFF;
    tick(); chk_a("glt_hi", 8'h00, 1'b0, 1'b1, 8'd0);
    din_a = 8'h00;
    tick(); chk_a("glt_abort", 8'h00, 1'b0, 1'b0, 8'd1);
    tick(); chk_a("glt_idle", 8'h00, 1'b0, 1'b0, 8'd1);

    // Clear, then restart 11 -> 22
    clr_a = 1'b1;
    tick(); chk_a("clr", 8'h00, 1'b0, 1'b0, 8'd0);
    clr_a = 1'b0;
    din_a = 8'h11;
    tick(); chk_a("rs_11a", 8'h00, 1'b0, 1'b1, 8'd0);
    tick(); chk_a("rs_11b", 8'h00, 1'b0, 1'b1, 8'd0);
    din_a = 8'h22; sb_a.push_back(8'h22);
    tick(); chk_a("rs_f0", 8'h00, 1'b0, 1'b1, 8'd1);
    tick(); chk_a("rs_f1", 8'h00, 1'b0, 1'b1, 8'd1);
    tick(); chk_a("rs_f2", 8'h22, 1'b1, 1'b0, 8'd1);
    tick(); chk_a("rs_f3", 8'h22, 1'b0, 1'b0, 8'd1);

    // Reset while qualifying 44: candidate discarded
    din_a = 8'h44;
    tick(); chk_a("mq_busy", 8'h22, 1'b0, 1'b1, 8'd1);
    rst = 1'b1;
    tick(); chk_a("mq_rst", 8'h00, 1'b0, 1'b0, 8'd0);
    rst = 1'b0; din_a = 8'h00;
    repeat (4) tick();
    chk_a("mq_after", 8'h00, 1'b0, 1'b0, 8'd0);

    // Saturation with a 2-bit glitch counter
    for (int i = 0; i < 5; i++) begin
      din_s = 8'hFF;
      tick(); chk("sat.busy", 32'(busy_s), 32'd1);
      din_s = 8'h00;
      tick(); chk("sat.gc", 32'(gc_s), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    din_s = 8'hFF;
    tick();
    din_s = 8'h00; clr_s = 1'b1;
    tick(); chk("sat.clr_gc", 32'(gc_s), 32'd0);
    chk("sat.clr_busy", 32'(busy_s), 32'd0);
    clr_s = 1'b0;
    tick(); chk("sat.after_gc", 32'(gc_s), 32'd0);
    chk("sat.out", 32'(dout_s), 32'd0);

    // STBLCYC=1: data_out follows every change one cycle later
    din_o = 8'h01; sb_o.push_back(8'h01);
    tick(); chk("one.01.out", 32'(dout_o), 32'h01); chk("one.01.vld", 32'(vld_o), 32'd1);
    din_o = 8'h02; sb_o.push_back(8'h02);
    tick(); chk("one.02.out", 32'(dout_o), 32'h02); chk("one.02.vld", 32'(vld_o), 32'd1);
    din_o = 8'h03; sb_o.push_back(8'h03);
    tick(); chk("one.03.out", 32'(dout_o), 32'h03); chk("one.03.vld", 32'(vld_o), 32'd1);
    chk("one.busy", 32'(busy_o), 32'd0);
    tick(); chk("one.hold.vld", 32'(vld_o), 32'd0); chk("one.hold.out", 32'(dout_o), 32'h03);
    din_o = 8'h00; sb_o.push_back(8'h00);
    tick(); chk("one.00.out", 32'(dout_o), 32'h00);
    tick();

    @(negedge clk); #1;
    chk("sb_a.left", 32'(sb_a.size()), 32'd0);
    chk("sb_s.left", 32'(sb_s.size()), 32'd0);
    chk("sb_o.left", 32'(sb_o.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
